// File: rtl/softmax_row_streamer.sv
// Frame buffer that captures a full softmax result matrix in one cycle and
// replays it one row per active-low valid/ready transfer, with end-of-frame pulse.
module softmax_row_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 128,
    parameter int COLS       = 128,
    parameter int IDX_WIDTH  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                            clk_p,
    input  logic                            rst_p,
    input  logic [DATA_WIDTH*ROWS*COLS-1:0] matrix,
    input  logic                            input_valid_n,
    output logic                            input_ready_n,
    output logic [DATA_WIDTH*COLS-1:0]      row_data,
    output logic [IDX_WIDTH-1:0]            row_index,
    output logic                            row_last,
    output logic                            row_valid_n,
    input  logic                            row_ready_n,
    output logic                            frame_done_n
);

    localparam int                   ROW_W    = DATA_WIDTH * COLS;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(ROWS - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [0:0]       state;
    logic [ROW_W-1:0] frame_buf [ROWS];
    logic [ROW_W-1:0] sel_row;
    logic             capture;
    logic             transfer;
    logic             final_xfer;

    assign capture    = (state == ST_IDLE) && !input_valid_n;
    assign transfer   = (state == ST_STREAM) && !row_ready_n;
    assign final_xfer = transfer && (row_index == LAST_IDX);

    always_ff @(posedge clk_p) begin
        if (rst_p) begin
            state        <= ST_IDLE;
            row_index    <= '0;
            frame_done_n <= 1'b1;
        end else begin
            frame_done_n <= 1'b1;
            if (state == ST_IDLE) begin
                if (capture) begin
                    state     <= ST_STREAM;
                    row_index <= '0;
                end
            end else begin
                if (final_xfer) begin
                    state        <= ST_IDLE;
                    row_index    <= '0;
                    frame_done_n <= 1'b0;
                end else if (transfer) begin
                    row_index <= row_index + 1'b1;
                end
            end
        end
    end

    // Buffer content is meaningless outside a frame, so it carries no reset.
    always_ff @(posedge clk_p) begin
        if (capture) begin
            for (int r = 0; r < ROWS; r++) begin
                frame_buf[r] <= matrix[r*ROW_W +: ROW_W];
            end
        end
    end

    always_comb begin
        sel_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_index == IDX_WIDTH'(r)) begin
                sel_row = frame_buf[r];
            end
        end
    end

    // Row data is forced to zero while idle so stale buffer contents never leak out.
    assign row_valid_n   = (state != ST_STREAM);
    assign input_ready_n = (state == ST_STREAM);
    assign row_data      = row_valid_n ? '0 : sel_row;
    assign row_last      = !row_valid_n && (row_index == LAST_IDX);

endmodule
